// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: word width, control word width and the
// occupancy state of a skid-buffered pipeline stage.
package lc3b_types;

    localparam int LC3B_WORD_W = 16;
    // Packed width of lc3b_control_word; pipeline stages size CTRL_W from this.
    localparam int LC3B_CTRL_W = 16;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

    // Number of entries held in a given state.
    function automatic logic [1:0] state_occ(input pipe_state_t s);
        case (s)
            PS_ONE:  state_occ = 2'd1;
            PS_FULL: state_occ = 2'd2;
            default: state_occ = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register of a pipeline stage. On load it captures either the
// upstream input or the skid entry; otherwise it holds its value.
module pipe_slot #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         sel_skid_i,
    input  logic [W-1:0] in_d_i,
    input  logic [W-1:0] skid_d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Capture the selected source only on load; hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            data_q <= '0;
        else if (load_i)
            data_q <= sel_skid_i ? skid_d_i : in_d_i;
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline latch with a 2-entry skid buffer and a synchronous
// flush for branch squash. in_ready is a register, so no combinational path
// runs from out_ready back upstream.
// Optional feature: define PIPE_STAGE_BUBBLE_ZERO_EN to drive all-zero
// words/control (a NOP) downstream whenever out_valid is low.
module pipe_stage_skid
    import lc3b_types::*;
#(
    parameter int WORD_W    = LC3B_WORD_W,
    parameter int NUM_WORDS = 4,
    parameter int CTRL_W    = LC3B_CTRL_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_WORDS*WORD_W-1:0] in_words,
    input  logic [CTRL_W-1:0]           in_ctrl,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_WORDS*WORD_W-1:0] out_words,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [1:0]                  occupancy
);

    localparam int DW = NUM_WORDS*WORD_W;
    localparam int PW = DW + CTRL_W;

    pipe_state_t state_q, state_d;
    logic        in_ready_q;
    logic        accept, drain;
    logic        load_main, main_from_skid, load_skid;
    logic [PW-1:0] in_pl, main_pl, skid_pl;

    assign in_pl = {in_ctrl, in_words};

    // An entry offered during flush is dropped even if we look ready.
    assign accept = in_valid & in_ready_q & ~flush;
    assign drain  = (state_q != PS_EMPTY) & out_ready;

    // Next state and slot load enables; flush squashes and blocks all loads
    // so payload contents stay put.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = PS_EMPTY;
        end else begin
            case (state_q)
                PS_EMPTY: if (accept) begin
                    load_main = 1'b1;
                    state_d   = PS_ONE;
                end
                PS_ONE: begin
                    if (accept && drain) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = PS_FULL;
                    end else if (drain) begin
                        state_d   = PS_EMPTY;
                    end
                end
                PS_FULL: if (drain) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = PS_ONE;
                end
                default: state_d = PS_EMPTY;
            endcase
        end
    end

    // State plus the registered upstream ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PS_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != PS_FULL);
        end
    end

    pipe_slot #(.W(PW)) u_main (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load_main),
        .sel_skid_i(main_from_skid),
        .in_d_i    (in_pl),
        .skid_d_i  (skid_pl),
        .q_o       (main_pl)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load_skid),
        .sel_skid_i(1'b0),
        .in_d_i    (in_pl),
        .skid_d_i  ({PW{1'b0}}),
        .q_o       (skid_pl)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != PS_EMPTY);
    assign occupancy = state_occ(state_q);

`ifdef PIPE_STAGE_BUBBLE_ZERO_EN
    assign {out_ctrl, out_words} = out_valid ? main_pl : {PW{1'b0}};
`else
    assign {out_ctrl, out_words} = main_pl;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure,
// flush, bubble payload, and a random-stall scoreboard run.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_words;
    logic [15:0] in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_words;
    logic [15:0] out_ctrl;
    logic [1:0]  occupancy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.WORD_W(16), .NUM_WORDS(4), .CTRL_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_words (in_words),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_words(out_words),
        .out_ctrl (out_ctrl),
        .occupancy(occupancy)
    );

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // words = {aluval, rdata, instr, pc}
    function automatic logic [63:0] mkw(input logic [15:0] pc, input logic [15:0] ins);
        mkw = {16'hA5A5 ^ pc, 16'h0F0F, ins, pc};
    endfunction

    task automatic offer(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                         input logic [15:0] c);
        in_valid = v;
        in_words = mkw(pc, ins);
        in_ctrl  = c;
    endtask

    logic [79:0] sb[$];
    logic [63:0] wA, wB, wC;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_words = '0; in_ctrl = '0;
        #1;
        chk("rst_vld",  {79'd0, out_valid}, 80'd0);
        chk("rst_rdy",  {79'd0, in_ready},  80'd1);
        chk("rst_occ",  {78'd0, occupancy}, 80'd0);
        chk("rst_data", {out_ctrl, out_words}, 80'd0);
        step(); step();
        reset = 1'b0;
        step();

        // Streaming: one entry per cycle, one cycle delayed.
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            offer(1'b1, 16'h3000 + 16'(2*k), 16'h5000 + 16'(k), 16'h0100 + 16'(k));
            step();
            chk("str_pc",  {64'd0, out_words[15:0]}, {64'd0, 16'h3000 + 16'(2*k)});
            chk("str_occ", {78'd0, occupancy}, 80'd1);
            chk("str_rdy", {79'd0, in_ready},  80'd1);
        end
        in_valid = 1'b0;
        step();
        chk("str_empty", {79'd0, out_valid}, 80'd0);

        // Backpressure: A, B fill both slots, C waits upstream.
        wA = mkw(16'h3000, 16'h1111);
        wB = mkw(16'h3002, 16'h2222);
        wC = mkw(16'h3004, 16'h3333);
        out_ready = 1'b0;
        offer(1'b1, 16'h3000, 16'h1111, 16'h00A0); step();
        chk("bp_occ1", {78'd0, occupancy}, 80'd1);
        offer(1'b1, 16'h3002, 16'h2222, 16'h00B0); step();
        chk("bp_occ2", {78'd0, occupancy}, 80'd2);
        chk("bp_rdy0", {79'd0, in_ready},  80'd0);
        offer(1'b1, 16'h3004, 16'h3333, 16'h00C0); step();
        chk("bp_hold", {16'd0, out_words}, {16'd0, wA});
        chk("bp_occ2b", {78'd0, occupancy}, 80'd2);
        out_ready = 1'b1;
        step();
        chk("bp_B", {out_ctrl, out_words}, {16'h00B0, wB});
        chk("bp_occB", {78'd0, occupancy}, 80'd1);
        step();
        chk("bp_C", {out_ctrl, out_words}, {16'h00C0, wC});
        in_valid = 1'b0;
        step();
        chk("bp_done", {79'd0, out_valid}, 80'd0);

        // Flush in FULL with D offered: D dropped, stage empties.
        out_ready = 1'b0;
        offer(1'b1, 16'h3000, 16'h1111, 16'h00A0); step();
        offer(1'b1, 16'h3002, 16'h2222, 16'h00B0); step();
        chk("fl_full", {78'd0, occupancy}, 80'd2);
        flush = 1'b1;
        offer(1'b1, 16'h300D, 16'hDDDD, 16'h00D0);
        step();
        flush = 1'b0;
        chk("fl_vld", {79'd0, out_valid}, 80'd0);
        chk("fl_occ", {78'd0, occupancy}, 80'd0);
        chk("fl_rdy", {79'd0, in_ready},  80'd1);
        in_valid = 1'b0;
        step();
        chk("fl_noD", {79'd0, out_valid}, 80'd0);
`ifndef PIPE_STAGE_BUBBLE_ZERO_EN
        chk("fl_keep", {16'd0, out_words}, {16'd0, wA});
`endif

        // Bubble contents after draining an entry with instruction 0x1234.
        out_ready = 1'b1;
        offer(1'b1, 16'h3010, 16'h1234, 16'hBEEF); step();
        chk("bub_vld", {79'd0, out_valid}, 80'd1);
        in_valid = 1'b0;
        step();
        chk("bub_empty", {79'd0, out_valid}, 80'd0);
`ifdef PIPE_STAGE_BUBBLE_ZERO_EN
        chk("bub_zero", {out_ctrl, out_words}, 80'd0);
`else
        chk("bub_stale", {64'd0, out_words[31:16]}, {64'd0, 16'h1234});
`endif

        // Random stalls with a scoreboard; in_ready must ignore out_ready.
        for (int n = 0; n < 100; n++) begin
            logic r0;
            logic acc, drn;
            if (!in_valid || in_ready)
                offer(1'($urandom_range(0, 3) != 0), 16'h4000 + 16'(2*n),
                      16'($urandom), 16'($urandom));
            r0 = in_ready;
            out_ready = ~out_ready;
            #1;
            chk("rnd_rdy_comb", {79'd0, in_ready}, {79'd0, r0});
            out_ready = 1'($urandom_range(0, 2) != 0);
            #1;
            acc = in_valid & in_ready;
            drn = out_valid & out_ready;
            if (drn) begin
                if (sb.size() == 0) chk("rnd_spurious", 80'd1, 80'd0);
                else chk("rnd_data", {out_ctrl, out_words}, sb.pop_front());
            end
            if (acc) sb.push_back({in_ctrl, in_words});
            step();
        end
        in_valid = 1'b0;
        chk("rnd_occ", {78'd0, occupancy}, 80'(sb.size()));

        // Reset mid-stream while FULL.
        out_ready = 1'b0;
        offer(1'b1, 16'h3000, 16'h1111, 16'h00A0); step();
        offer(1'b1, 16'h3002, 16'h2222, 16'h00B0); step();
        offer(1'b1, 16'h3004, 16'h3333, 16'h00C0); step();
        chk("mr_occ2", {78'd0, occupancy}, 80'd2);
        #2 reset = 1'b1;
        #1;
        chk("mr_vld",  {79'd0, out_valid}, 80'd0);
        chk("mr_occ",  {78'd0, occupancy}, 80'd0);
        chk("mr_data", {16'd0, out_words}, 80'd0);
        step();
        chk("mr_rdy", {79'd0, in_ready}, 80'd1);
        reset = 1'b0;
        in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed single-load pipeline latches between LC-3b stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries NUM_WORDS data words plus a control word between two stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream ready is fully registered, plus a synchronous flush for branch squash.
- One instance per stage boundary; the hazard unit drives flush and out_ready.

Parameters:
- WORD_W, 16, width of each data word (lc3b_word)
- NUM_WORDS, 4, number of data words carried (e.g. pc, instruction, rdata, aluval)
- CTRL_W, 16, width of control payload (matches packed lc3b_control_word width)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage can accept; registered, depends only on state
- in_words  in  NUM_WORDS*WORD_W  packed words, word 0 at LSBs
- in_ctrl  in  CTRL_W  control payload
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream consumes
- out_words  out  NUM_WORDS*WORD_W  head entry words
- out_ctrl  out  CTRL_W  head entry control
- occupancy  out  2  entries held (0..2)

Behaviour:
- Storage: main slot (drives outputs) and skid slot. State encoding: EMPTY (0), ONE (main valid), FULL (main+skid valid).
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Reset: state EMPTY; out_valid=0, in_ready=1, occupancy=0; out_words=0, out_ctrl=0, skid payload=0.
- in_ready = (state != FULL), registered: equivalently the registered inverse of skid-valid.
- out_valid = (state != EMPTY). Latency: an accepted entry appears on outputs the next cycle.
- EMPTY: accept -> load main, go ONE.
- ONE:
  - accept & drain -> load main with input, stay ONE.
  - accept & !drain -> load skid, go FULL.
  - !accept & drain -> go EMPTY.
  - otherwise hold.
- FULL (in_ready=0, so no accept):
  - drain -> move skid into main, go ONE.
  - otherwise hold.
- Payload registers change only on load/move. Otherwise they hold (no spurious toggling).
- flush has priority over everything:
  - Next state EMPTY and in_ready=1 next cycle.
  - An input offered in the flush cycle is dropped (not accepted, even if in_ready=1).
  - A drain in the flush cycle still counts as consumed downstream.
- Payload contents on flush are unchanged (see optional feature).
- Reset mid-operation returns immediately (asynchronously) to reset values; in-flight entries are lost.
- Ordering is strictly FIFO. No entry is duplicated or lost except by flush or reset.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: PIPE_STAGE_BUBBLE_ZERO_EN.
- Defined: whenever out_valid=0, out_words and out_ctrl are driven to all zeros (combinational mask on main payload). Downstream sees instruction 0x0000 (BR with nzp=000, a NOP) and an all-zero, inert control word during bubbles.
- Not defined: outputs show the stale main payload while out_valid=0. Consumers must qualify with out_valid.

Decomposition:
- lc3b_types package: WORD_W default (16), a pipe_state_t enum {PS_EMPTY, PS_ONE, PS_FULL}, and an lc3b_control_word packed width constant used for CTRL_W.
- Sub-module pipe_slot: a single payload register with load enable, mux-select input (in vs. skid), and async reset. Instantiated twice (main, skid).

Test Plan:
- Reset asserted mid-stream with occupancy=2 -> same cycle: out_valid=0, occupancy=0, out_words=0; next edge in_ready=1.
- Streaming with out_ready=1, in_valid=1 and words pc=0x3000+2k -> one entry per cycle, out_words pc sequence 0x3000, 0x3002… one cycle delayed, occupancy stays 1, in_ready stays 1.
- out_ready=0 with entries A (pc 0x3000), B (0x3002) sent -> occupancy=2, in_ready=0, C held upstream. Then out_ready=1 -> A, B, C emerge in order on consecutive cycles; nothing lost or duplicated.
- FULL state, assert flush with in_valid=1 (entry D) -> next cycle: out_valid=0, occupancy=0, in_ready=1; D never appears at the output.
- Macro defined, out_valid=0 after drain of entry with instruction 0x1234 -> out_words=0, out_ctrl=0. Macro undefined -> instruction field still reads 0x1234.
- Simultaneous accept+drain in ONE state for 100 random-stall cycles -> scoreboard matches the input sequence exactly; in_ready never depends combinationally on out_ready.
